block_store_sequencer: RTL and testbench

BLOCK_STORE_SEQUENCER -- requirements
Module: block_store_sequencer

---
 rtl/block_store_pkg.sv | 14 +
 rtl/block_store_sequencer_if.sv | 28 ++
 rtl/block_store_sequencer.sv | 98 +++++++++
 tb/tb_block_store_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/block_store_pkg.sv
// Shared constants and state encoding for the 8x8 block store sequencer.
package block_store_pkg;

    localparam int unsigned BLOCK_WORDS = 64;
    localparam int unsigned MEM_WORDS   = 2048;
    localparam int unsigned MAX_BLOCKS  = MEM_WORDS / BLOCK_WORDS;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/block_store_sequencer_if.sv
// Handshake and status bundle between a block producer/consumer and the sequencer.
interface block_store_sequencer_if #(
    parameter int unsigned CNT_W = 32
);

    logic             start;
    logic [5:0]       cfg_blocks;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic             store_we;
    logic [CNT_W-1:0] counter;
    logic             slice_valid;
    logic [5:0]       slice_len;
    logic             slice_ack;
    logic             busy;

    modport master (
        output start, cfg_blocks, in_valid, flush, slice_ack,
        input  in_ready, store_we, counter, slice_valid, slice_len, busy
    );

    modport slave (
        input  start, cfg_blocks, in_valid, flush, slice_ack,
        output in_ready, store_we, counter, slice_valid, slice_len, busy
    );

endinterface

// File: rtl/block_store_sequencer.sv
// Sequences up to MAX_BLOCKS 8x8 blocks into a slice store and hands the slice
// to a consumer; the store addresses each block with the zero-latency counter.
module block_store_sequencer #(
    parameter int unsigned MAX_BLOCKS = block_store_pkg::MAX_BLOCKS,
    parameter int unsigned CNT_W      = 32
) (
    input logic                    clock,
    input logic                    reset,
    block_store_sequencer_if.slave bus
);

    import block_store_pkg::*;

    localparam logic [5:0] MaxLen = 6'(MAX_BLOCKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [5:0]       limit_q, limit_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       cfg_clamped;
    logic [5:0]       cnt_low;
    logic             in_ready;
    logic             accept;
    logic             last;

    assign cfg_clamped = ((bus.cfg_blocks == 6'd0) || (bus.cfg_blocks > MaxLen)) ?
                         MaxLen : bus.cfg_blocks;

    // Gating by reset keeps the store quiet during the reset cycle itself.
    assign in_ready = (state_q == ST_FILL) && !reset;
    assign accept   = bus.in_valid && in_ready;
    assign last     = (counter_q == CNT_W'(limit_q - 6'd1));
    assign cnt_low  = counter_q[5:0];

    assign bus.in_ready    = in_ready;
    assign bus.store_we    = accept;
    assign bus.counter     = counter_q;
    assign bus.slice_valid = (state_q == ST_DONE) && !reset;
    assign bus.slice_len   = len_q;
    assign bus.busy        = (state_q != ST_IDLE) && !reset;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        limit_d   = limit_q;
        len_d     = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_FILL;
                    counter_d = '0;
                    limit_d   = cfg_clamped;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    if (last) begin
                        state_d = ST_DONE;
                        len_d   = limit_q;
                    end else if (bus.flush) begin
                        state_d = ST_DONE;
                        len_d   = cnt_low + 6'd1;
                    end else begin
                        counter_d = counter_q + CNT_W'(1);
                    end
                end else if (bus.flush && (counter_q != '0)) begin
                    state_d = ST_DONE;
                    len_d   = cnt_low;
                end
            end
            ST_DONE: begin
                if (bus.slice_ack) begin
                    state_d   = ST_IDLE;
                    counter_d = '0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            limit_q   <= MaxLen;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            limit_q   <= limit_d;
            len_q     <= len_d;
        end
    end

endmodule

// File: tb/tb_block_store_sequencer.sv
// Directed vector table plus hand-written multi-cycle sequences for the block store sequencer.
module tb_block_store_sequencer;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    block_store_sequencer_if #(.CNT_W(32)) bus ();

    block_store_sequencer #(
        .MAX_BLOCKS(32),
        .CNT_W     (32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        start;
        logic [5:0]  cfg;
        logic        iv;
        logic        fl;
        logic        ack;
        logic        rdy;
        logic        we;
        int unsigned cnt;
        logic        sv;
        logic [5:0]  len;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic start, input logic [5:0] cfg,
                       input logic iv, input logic fl, input logic ack,
                       input logic rdy, input logic we, input int unsigned cnt,
                       input logic sv, input logic [5:0] len, input logic busy);
        vec_t v;
        v.rst = rst; v.start = start; v.cfg = cfg; v.iv = iv; v.fl = fl; v.ack = ack;
        v.rdy = rdy; v.we = we; v.cnt = cnt; v.sv = sv; v.len = len; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic start, input logic [5:0] cfg,
                         input logic iv, input logic fl, input logic ack);
        reset          = rst;
        bus.start      = start;
        bus.cfg_blocks = cfg;
        bus.in_valid   = iv;
        bus.flush      = fl;
        bus.slice_ack  = ack;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".in_ready"},    longint'(bus.in_ready),    longint'(v.rdy));
        chk({tag, ".store_we"},    longint'(bus.store_we),    longint'(v.we));
        chk({tag, ".counter"},     longint'(bus.counter),     longint'(v.cnt));
        chk({tag, ".slice_valid"}, longint'(bus.slice_valid), longint'(v.sv));
        chk({tag, ".slice_len"},   longint'(bus.slice_len),   longint'(v.len));
        chk({tag, ".busy"},        longint'(bus.busy),        longint'(v.busy));
    endtask

    initial begin
        logic [5:0] cfgs [2];
        n_cmp = 0;
        n_bad = 0;
        drive(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);

        //   rst st cfg iv fl ack | rdy we cnt sv len busy
        add(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // cfg=4 continuous valid
        add(0, 1, 4, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 2, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 3, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0,  0, 0, 3, 1, 4, 1);
        add(0, 1, 4, 0, 0, 1,  0, 0, 3, 1, 4, 1);
        add(0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 4, 0);
        // cfg=2 gapped valid, ack ignored in FILL
        add(0, 1, 2, 0, 0, 0,  0, 0, 0, 0, 4, 0);
        add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 4, 1);
        add(0, 0, 0, 0, 0, 1,  1, 0, 1, 0, 4, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 4, 1);
        add(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 2, 1);
        // cfg=8: flush at counter 0 ignored, flush after 3 accepts
        add(0, 1, 8, 0, 0, 0,  0, 0, 0, 0, 2, 0);
        add(0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 2, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 2, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 2, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 2, 0, 2, 1);
        add(0, 0, 0, 0, 1, 0,  1, 0, 3, 0, 2, 1);
        add(0, 0, 0, 0, 0, 1,  0, 0, 3, 1, 3, 1);
        // cfg=8: flush together with the third accept
        add(0, 1, 8, 0, 0, 0,  0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 3, 1);
        add(0, 0, 0, 1, 0, 0,  1, 1, 1, 0, 3, 1);
        add(0, 0, 0, 1, 1, 0,  1, 1, 2, 0, 3, 1);
        add(0, 0, 0, 0, 0, 1,  0, 0, 2, 1, 3, 1);
        // cfg=1 single block
        add(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 3, 0);
        add(0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 3, 1);
        add(0, 0, 0, 1, 0, 1,  0, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i].rst, vecs[i].start, vecs[i].cfg, vecs[i].iv, vecs[i].fl, vecs[i].ack);
            #1 chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Full-size slice: cfg 0 and an out-of-range cfg both clamp to 32
        cfgs[0] = 6'd0;
        cfgs[1] = 6'd40;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            drive(1'b0, 1'b1, cfgs[c], 1'b0, 1'b0, 1'b0);
            @(negedge clock);
            drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 32; i++) begin
                #1;
                chk($sformatf("full%0d.we[%0d]", c, i), longint'(bus.store_we), 1);
                chk($sformatf("full%0d.cnt[%0d]", c, i), longint'(bus.counter), longint'(i));
                @(negedge clock);
            end
            #1;
            chk($sformatf("full%0d.in_ready_after", c), longint'(bus.in_ready), 0);
            chk($sformatf("full%0d.slice_valid", c), longint'(bus.slice_valid), 1);
            chk($sformatf("full%0d.slice_len", c), longint'(bus.slice_len), 32);
            chk($sformatf("full%0d.cnt_max", c), longint'(bus.counter), 31);
            drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
            @(negedge clock);
            drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
            #1 chk($sformatf("full%0d.busy_after_ack", c), longint'(bus.busy), 0);
        end

        // Reset at counter=5 abandons the slice
        @(negedge clock);
        drive(1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("rst.cnt[%0d]", i), longint'(bus.counter), longint'(i));
            @(negedge clock);
        end
        #1 chk("rst.cnt_before", longint'(bus.counter), 5);
        reset = 1'b1;
        #1;
        chk("rst.in_ready_during", longint'(bus.in_ready), 0);
        chk("rst.store_we_during", longint'(bus.store_we), 0);
        chk("rst.busy_during", longint'(bus.busy), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst.busy_after", longint'(bus.busy), 0);
        chk("rst.cnt_after", longint'(bus.counter), 0);
        chk("rst.len_after", longint'(bus.slice_len), 0);
        chk("rst.in_ready_after", longint'(bus.in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1 chk($sformatf("rst.no_valid[%0d]", i), longint'(bus.slice_valid), 0);
        end

        // DONE held 10 cycles without ack, in_valid kept high
        @(negedge clock);
        drive(1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("hold.sv[%0d]", k), longint'(bus.slice_valid), 1);
            chk($sformatf("hold.len[%0d]", k), longint'(bus.slice_len), 2);
            chk($sformatf("hold.we[%0d]", k), longint'(bus.store_we), 0);
            chk($sformatf("hold.cnt[%0d]", k), longint'(bus.counter), 1);
            @(negedge clock);
        end
        drive(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b1);
        #1 chk("hold.sv_at_ack", longint'(bus.slice_valid), 1);
        @(negedge clock);
        drive(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hold.busy_after_ack", longint'(bus.busy), 0);
        chk("hold.sv_after_ack", longint'(bus.slice_valid), 0);
        chk("hold.cnt_after_ack", longint'(bus.counter), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
